alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Sequencing front end for the 8-bit `alu`. It holds operand registers A and B and accepts 12-bit instructions through a valid/ready handshake. For each instruction it drives the ALU's `a`, `b` and `s` inputs, captures the ALU result into A or B, and optionally keeps Z/N/C status flags. It sits directly upstream of the ALU, feeding it, and consumes the ALU's `out`.

## Interface
- `WIDTH`, 8, datapath width. Fixed at 8 to match the ALU.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  block can accept an instruction.
- `instr`  in  12  `[11:8]` opcode, `[7:0]` immediate.
- `alu_a`  out  8  to ALU `a`.
- `alu_b`  out  8  to ALU `b`.
- `alu_s`  out  3  to ALU `s`.
- `alu_out`  in  8  from ALU `out`.
- `reg_a`  out  8  register A.
- `reg_b`  out  8  register B.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an undefined opcode.
- `flag_z`  out  1  zero flag.
- `flag_n`  out  1  negative flag.
- `flag_c`  out  1  carry/borrow flag.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `instr_ready`=1. When `instr_valid`=1, latch `instr` into the internal IR and go to EXEC. Otherwise stay in IDLE.
- EXEC: drive the ALU from the IR opcode. At the end of the cycle, write `alu_out` to the destination register and update flags. Go to DONE.
- DONE: `done`=1, plus `illegal`=1 if applicable. Go to IDLE.
- Opcodes, given as (alu_a, alu_b, alu_s → destination):
  - 0 MOVA: (0, imm, 000 → A)
  - 1 MOVB: (0, imm, 000 → B)
  - 2 ADD: (A, B, 000 → A)
  - 3 SUB: (A, B, 001 → A)
  - 4 AND: (A, B, 010 → A)
  - 5 OR: (A, B, 011 → A)
  - 6 ADDI: (A, imm, 000 → A)
  - 7 MOVBA: (A, 0, 000 → B)
  - 8–15: no register write and no flag change; `illegal` pulses in DONE.
- Outside EXEC, drive `alu_a`=A, `alu_b`=B, `alu_s`=000.
- All arithmetic is modulo 256. The result register takes `alu_out` exactly; it is not recomputed locally.
- Flags (opcodes 2–6 only; all other opcodes leave flags unchanged):
  - Z = (`alu_out`==0).
  - N = `alu_out[7]`.
  - C for ADD/ADDI = bit 8 of the 9-bit sum A + operand, computed locally.
  - C for SUB = 1 when A < B unsigned (borrow).
  - C for AND/OR = 0.
- Reset: A, B, IR and flags clear to 0; FSM goes to IDLE.
- Reset values of outputs: `instr_ready`=1, `done`=0, `illegal`=0, `alu_a`=`alu_b`=0, `alu_s`=000, `reg_a`=`reg_b`=0, all flags 0.
- Reset in EXEC or DONE aborts the instruction: no register write and no `done` pulse.

## Timing
- Instruction accepted at edge t (`instr_valid` & `instr_ready`).
- EXEC occupies cycle t..t+1. The register write lands at edge t+1.
- `done` is high during t+1..t+2, and the new `reg_a`/`reg_b`/flags are already visible in that cycle.
- `instr_ready` returns high after edge t+2. Throughput is one instruction per 3 cycles.
- `instr` is sampled only at accept; later changes to `instr` are ignored.
- `instr_valid` may stay high back-to-back. The next instruction is taken at the first IDLE edge.
- The ALU is combinational, so `alu_out` must settle within the EXEC cycle. No multicycle path is allowed.

## Configuration
- `ALU_CTRL_FLAGS_EN` defined: flag registers and the local carry logic are built as specified above.
- `ALU_CTRL_FLAGS_EN` undefined: no flag registers or carry logic are built. `flag_z`, `flag_n` and `flag_c` are tied to 0. All other behaviour and timing are identical.

## Test plan
- MOVA 0x05, then MOVB 0x03, then ADD → `reg_a`=0x08, Z=0, N=0, C=0. Each `done` comes 2 cycles after its accept edge, with the next accept 3 cycles after the previous one.
- A=0xF0, ADDI 0x20 → `reg_a`=0x10, C=1, N=0. During EXEC, `alu_a`=0xF0, `alu_b`=0x20, `alu_s`=000.
- A=0x03, B=0x05, SUB → `reg_a`=0xFE, C=1, N=1, Z=0. Then AND with B=0x00 → `reg_a`=0x00, Z=1, C=0.
- Opcode 0xA with A=0x11 → `illegal` and `done` pulse together; A, B and flags are unchanged.
- Assert `rst` in the EXEC cycle of MOVA 0x7F → no `done`, `reg_a`=0, `instr_ready`=1 on the next cycle.
- Build without `ALU_CTRL_FLAGS_EN`, repeat the SUB case → `reg_a`=0xFE, all flags stay 0.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Instruction handshake and ALU operand/result bundle between alu_ctrl and its neighbours.
// The slave modport is the alu_ctrl side; the master modport is the instruction source plus the ALU.
interface alu_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_s;
    logic [7:0]  alu_out;

    modport master (
        output instr_valid, instr, alu_out,
        input  instr_ready, alu_a, alu_b, alu_s
    );

    modport slave (
        input  instr_valid, instr, alu_out,
        output instr_ready, alu_a, alu_b, alu_s
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencing front end for the 8-bit combinational ALU: IDLE/EXEC/DONE, one instruction per 3 cycles.
// Define ALU_CTRL_FLAGS_EN to build the Z/N/C flag registers; otherwise the flags are tied to 0.
module alu_ctrl (
    input  logic             clk,
    input  logic             rst,
    alu_ctrl_if.slave        bus,
    output logic [7:0]       reg_a,
    output logic [7:0]       reg_b,
    output logic             done,
    output logic             illegal,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);
    localparam int WIDTH = 8;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [11:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] imm;

    assign opcode = ir_q[11:8];
    assign imm    = ir_q[7:0];
    assign reg_a  = a_q;
    assign reg_b  = b_q;

    // The destination register takes alu_out as-is; nothing is recomputed locally.
    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        a_d             = a_q;
        b_d             = b_q;
        bus.instr_ready = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        bus.alu_a       = a_q;
        bus.alu_b       = b_q;
        bus.alu_s       = 3'b000;
        unique case (state_q)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                case (opcode)
                    4'd0: begin
                        bus.alu_a = '0;
                        bus.alu_b = imm;
                        a_d       = bus.alu_out;
                    end
                    4'd1: begin
                        bus.alu_a = '0;
                        bus.alu_b = imm;
                        b_d       = bus.alu_out;
                    end
                    4'd2: a_d = bus.alu_out;
                    4'd3: begin
                        bus.alu_s = 3'b001;
                        a_d       = bus.alu_out;
                    end
                    4'd4: begin
                        bus.alu_s = 3'b010;
                        a_d       = bus.alu_out;
                    end
                    4'd5: begin
                        bus.alu_s = 3'b011;
                        a_d       = bus.alu_out;
                    end
                    4'd6: begin
                        bus.alu_b = imm;
                        a_d       = bus.alu_out;
                    end
                    4'd7: begin
                        bus.alu_b = '0;
                        b_d       = bus.alu_out;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                done    = 1'b1;
                illegal = opcode[3];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef ALU_CTRL_FLAGS_EN
    logic         z_q, z_d;
    logic         n_q, n_d;
    logic         c_q, c_d;
    logic [WIDTH:0] sum;

    // Carry is the ninth bit of the local add; SUB reports borrow, logic ops clear it.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        c_d = c_q;
        sum = {1'b0, a_q} + {1'b0, (opcode == 4'd6) ? imm : b_q};
        if (state_q == EXEC && opcode >= 4'd2 && opcode <= 4'd6) begin
            z_d = (bus.alu_out == '0);
            n_d = bus.alu_out[WIDTH-1];
            case (opcode)
                4'd2, 4'd6: c_d = sum[WIDTH];
                4'd3:       c_d = (a_q < b_q);
                default:    c_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
            c_q <= c_d;
        end
    end

    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the instruction set.
module tb_alu_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] reg_a, reg_b;
    logic       done, illegal, flag_z, flag_n, flag_c;

    always #5 clk = ~clk;

    alu_ctrl_if bus();

    alu_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .done    (done),
        .illegal (illegal),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_c  (flag_c)
    );

`ifdef ALU_CTRL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    // Stand-in for the downstream combinational ALU.
    always_comb begin
        case (bus.alu_s)
            3'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
            3'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
            default: bus.alu_out = 8'h00;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit fl(input bit v);
        return FLAGS_EN ? v : 1'b0;
    endfunction

    // Reference model: ph counts cycles since accept (0 = waiting, 1 = executing, 2 = retired).
    int         ph = 0;
    logic [3:0] m_op = 4'd0;
    logic [7:0] m_imm = 8'd0;
    int         e_a = 0, e_b = 0;
    bit         e_z = 1'b0, e_n = 1'b0, e_c = 1'b0;

    function automatic void modelRetire();
        int res;
        bit c;
        res = -1;
        c   = 1'b0;
        case (m_op)
            4'd0: e_a = int'(m_imm);
            4'd1: e_b = int'(m_imm);
            4'd2: begin res = e_a + e_b;              c = (res > 255);  end
            4'd3: begin res = e_a - e_b + 256;        c = (e_a < e_b);  end
            4'd4: res = e_a & e_b;
            4'd5: res = e_a | e_b;
            4'd6: begin res = e_a + int'(m_imm);      c = (res > 255);  end
            4'd7: e_b = e_a;
            default: ;
        endcase
        if (res >= 0) begin
            e_a = res % 256;
            e_z = fl(e_a == 0);
            e_n = fl(e_a >= 128);
            e_c = fl(c);
        end
    endfunction

    function automatic void expAlu(output int a, output int b, output int s);
        a = e_a;
        b = e_b;
        s = 0;
        case (m_op)
            4'd0, 4'd1: begin a = 0; b = int'(m_imm); end
            4'd2, 4'd3, 4'd4, 4'd5: s = int'(m_op) - 2;
            4'd6: b = int'(m_imm);
            4'd7: b = 0;
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ph  = 0;
            e_a = 0;
            e_b = 0;
            e_z = 1'b0;
            e_n = 1'b0;
            e_c = 1'b0;
        end else if (ph == 0) begin
            if (bus.instr_valid) begin
                m_op  = bus.instr[11:8];
                m_imm = bus.instr[7:0];
                ph    = 1;
            end
        end else if (ph == 1) begin
            modelRetire();
            ph = 2;
        end else begin
            ph = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    int x_a, x_b, x_s;
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("instr_ready", 32'(bus.instr_ready), 32'(ph == 0));
            checkOutput("done",        32'(done),            32'(ph == 2));
            checkOutput("illegal",     32'(illegal),         32'(ph == 2 && m_op >= 4'd8));
            checkOutput("reg_a",       32'(reg_a),           e_a);
            checkOutput("reg_b",       32'(reg_b),           e_b);
            checkOutput("flag_z",      32'(flag_z),          32'(e_z));
            checkOutput("flag_n",      32'(flag_n),          32'(e_n));
            checkOutput("flag_c",      32'(flag_c),          32'(e_c));
            if (ph != 1) begin
                checkOutput("alu_a_idle", 32'(bus.alu_a), e_a);
                checkOutput("alu_b_idle", 32'(bus.alu_b), e_b);
                checkOutput("alu_s_idle", 32'(bus.alu_s), 0);
            end else if (m_op < 4'd8) begin
                expAlu(x_a, x_b, x_s);
                checkOutput("alu_a_exec", 32'(bus.alu_a), x_a);
                checkOutput("alu_b_exec", 32'(bus.alu_b), x_b);
                checkOutput("alu_s_exec", 32'(bus.alu_s), x_s);
            end
        end
    end

    // Issue one instruction, report accept cycle, done latency, EXEC-cycle ALU drive and illegal.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] imm,
                                 output int acc, output int lat,
                                 output logic [7:0] xa, output logic [7:0] xb,
                                 output logic [2:0] xs, output logic ill);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_wait", 32'(bus.instr_ready), 1);
        bus.instr_valid = 1'b1;
        bus.instr       = {op, imm};
        @(posedge clk);
        #2;
        acc             = cyc;
        bus.instr_valid = 1'b0;
        bus.instr       = 12'($urandom);
        lat = 0;
        xa  = 8'h00;
        xb  = 8'h00;
        xs  = 3'b000;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                xa = bus.alu_a;
                xb = bus.alu_b;
                xs = bus.alu_s;
            end
        end while (!done && lat < 8);
        ill = illegal;
        checkOutput("done_latency", lat, 2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         acc0, acc1, acc2, lat;
        logic [7:0] xa, xb;
        logic [2:0] xs;
        logic       ill;

        bus.instr_valid = 1'b0;
        bus.instr       = 12'h000;
        rst             = 1'b1;
        @(posedge clk);
        #2 chk_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_ready", 32'(bus.instr_ready), 1);
        checkOutput("rst_reg_a", 32'(reg_a), 0);
        checkOutput("rst_alu_s", 32'(bus.alu_s), 0);
        checkOutput("rst_done",  32'(done), 0);

        $display("[TB] MOVA/MOVB/ADD");
        applyStimulus(4'd0, 8'h05, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'd1, 8'h03, acc1, lat, xa, xb, xs, ill);
        applyStimulus(4'd2, 8'h00, acc2, lat, xa, xb, xs, ill);
        checkOutput("accept_spacing_1", acc1 - acc0, 3);
        checkOutput("accept_spacing_2", acc2 - acc1, 3);
        checkOutput("add_reg_a", 32'(reg_a), 32'h08);
        checkOutput("add_z", 32'(flag_z), 32'(fl(1'b0)));
        checkOutput("add_c", 32'(flag_c), 32'(fl(1'b0)));

        $display("[TB] ADDI carry");
        applyStimulus(4'd0, 8'hF0, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'd6, 8'h20, acc0, lat, xa, xb, xs, ill);
        checkOutput("addi_exec_a", 32'(xa), 32'hF0);
        checkOutput("addi_exec_b", 32'(xb), 32'h20);
        checkOutput("addi_exec_s", 32'(xs), 0);
        checkOutput("addi_reg_a", 32'(reg_a), 32'h10);
        checkOutput("addi_c", 32'(flag_c), 32'(fl(1'b1)));
        checkOutput("addi_n", 32'(flag_n), 32'(fl(1'b0)));

        $display("[TB] SUB borrow then AND zero");
        applyStimulus(4'd0, 8'h03, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'd1, 8'h05, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'd3, 8'h00, acc0, lat, xa, xb, xs, ill);
        checkOutput("sub_reg_a", 32'(reg_a), 32'hFE);
        checkOutput("sub_c", 32'(flag_c), 32'(fl(1'b1)));
        checkOutput("sub_n", 32'(flag_n), 32'(fl(1'b1)));
        checkOutput("sub_z", 32'(flag_z), 32'(fl(1'b0)));
        applyStimulus(4'd1, 8'h00, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'd4, 8'h00, acc0, lat, xa, xb, xs, ill);
        checkOutput("and_reg_a", 32'(reg_a), 32'h00);
        checkOutput("and_z", 32'(flag_z), 32'(fl(1'b1)));
        checkOutput("and_c", 32'(flag_c), 32'(fl(1'b0)));

        $display("[TB] illegal opcode");
        applyStimulus(4'd0, 8'h11, acc0, lat, xa, xb, xs, ill);
        applyStimulus(4'hA, 8'h5A, acc0, lat, xa, xb, xs, ill);
        checkOutput("illegal_pulse", 32'(ill), 1);
        checkOutput("illegal_reg_a", 32'(reg_a), 32'h11);
        checkOutput("illegal_reg_b", 32'(reg_b), 32'h00);
        checkOutput("illegal_z", 32'(flag_z), 32'(fl(1'b1)));

        $display("[TB] reset during EXEC");
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 12'h07F;
        @(posedge clk);
        #2;
        bus.instr_valid = 1'b0;
        rst             = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_done",  32'(done), 0);
        checkOutput("abort_reg_a", 32'(reg_a), 0);
        checkOutput("abort_ready", 32'(bus.instr_ready), 1);
        @(negedge clk);
        checkOutput("abort_no_done", 32'(done), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst             = ($urandom_range(0, 59) == 0);
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr       = {4'($urandom_range(0, 9)), 8'($urandom)};
            if ($urandom_range(0, 15) == 0) bus.instr = 12'($urandom);
        end
        @(negedge clk);
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
